// File: rtl/hazard_mul_ctrl_pkg.sv
// Shared encodings for the hazard/multiply controller: forwarding selects and FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_t;

endpackage

// File: rtl/hazard_mul_ctrl_if.sv
// Bundle of datapath comparator/control inputs and the forward/stall/flush outputs.
interface hazard_mul_ctrl_if;
  logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_3E_M, Match_3E_W;
  logic Match_1E_M_Index, Match_1E_W_Index, Match_2E_M_Index, Match_2E_W_Index;
  logic Match_3E_M_Index, Match_3E_W_Index;
  logic Match_12D_E;
  logic RegWriteM, RegWriteW, WriteBackM, WriteBackW;
  logic MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic BranchTakenD;
  logic MulStartE;
  logic [1:0] ForwardAE, ForwardBE, ForwardCE;
  logic [1:0] ForwardAEIndex, ForwardBEIndex, ForwardCEIndex;
  logic StallF, StallD, StallE;
  logic FlushD, FlushE, FlushM;
  logic MulBusyE, MulDoneE;

  modport master (
    output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_3E_M, Match_3E_W,
    output Match_1E_M_Index, Match_1E_W_Index, Match_2E_M_Index, Match_2E_W_Index,
    output Match_3E_M_Index, Match_3E_W_Index, Match_12D_E,
    output RegWriteM, RegWriteW, WriteBackM, WriteBackW, MemtoRegE,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenD, MulStartE,
    input  ForwardAE, ForwardBE, ForwardCE, ForwardAEIndex, ForwardBEIndex, ForwardCEIndex,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE, MulDoneE
  );

  modport slave (
    input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_3E_M, Match_3E_W,
    input  Match_1E_M_Index, Match_1E_W_Index, Match_2E_M_Index, Match_2E_W_Index,
    input  Match_3E_M_Index, Match_3E_W_Index, Match_12D_E,
    input  RegWriteM, RegWriteW, WriteBackM, WriteBackW, MemtoRegE,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenD, MulStartE,
    output ForwardAE, ForwardBE, ForwardCE, ForwardAEIndex, ForwardBEIndex, ForwardCEIndex,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE, MulDoneE
  );
endinterface

// File: rtl/hazard_mul_ctrl_fwd_sel.sv
// One bypass mux select: the Memory-stage producer is younger, so it wins over Writeback.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic       matchM,
  input  logic       matchW,
  input  logic       weM,
  input  logic       weW,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (matchM && weM)      sel = FWD_M;
    else if (matchW && weW) sel = FWD_W;
  end

endmodule

// File: rtl/hazard_mul_ctrl.sv
// Forwarding selects, stall/flush strobes and the multi-cycle multiply hold FSM.
module hazard_mul_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  hazard_mul_ctrl_if.slave bus
);

  mul_state_t       r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  logic             w_busy, w_done;
  logic             w_ldr_stall, w_pc_pending;
  logic             w_flush_d;

  fwd_sel u_fwd_a  (.matchM(bus.Match_1E_M), .matchW(bus.Match_1E_W), .weM(bus.RegWriteM),
                    .weW(bus.RegWriteW), .sel(bus.ForwardAE));
  fwd_sel u_fwd_b  (.matchM(bus.Match_2E_M), .matchW(bus.Match_2E_W), .weM(bus.RegWriteM),
                    .weW(bus.RegWriteW), .sel(bus.ForwardBE));
  fwd_sel u_fwd_c  (.matchM(bus.Match_3E_M), .matchW(bus.Match_3E_W), .weM(bus.RegWriteM),
                    .weW(bus.RegWriteW), .sel(bus.ForwardCE));
  fwd_sel u_fwd_ai (.matchM(bus.Match_1E_M_Index), .matchW(bus.Match_1E_W_Index),
                    .weM(bus.WriteBackM), .weW(bus.WriteBackW), .sel(bus.ForwardAEIndex));
  fwd_sel u_fwd_bi (.matchM(bus.Match_2E_M_Index), .matchW(bus.Match_2E_W_Index),
                    .weM(bus.WriteBackM), .weW(bus.WriteBackW), .sel(bus.ForwardBEIndex));
  fwd_sel u_fwd_ci (.matchM(bus.Match_3E_M_Index), .matchW(bus.Match_3E_W_Index),
                    .weM(bus.WriteBackM), .weW(bus.WriteBackW), .sel(bus.ForwardCEIndex));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // The entry cycle counts as one, so the counter is loaded two short of the hold length.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.MulStartE) begin
          w_busy       = 1'b1;
          w_next_state = RUN;
          w_next_cnt   = CNT_W'(MUL_CYCLES - 2);
        end
      end
      RUN: begin
        if (r_cnt != '0) begin
          w_busy     = 1'b1;
          w_next_cnt = r_cnt - 1'b1;
        end else begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end
        if (bus.PCSrcW) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign w_ldr_stall  = bus.Match_12D_E & bus.MemtoRegE;
  assign w_pc_pending = bus.PCSrcD | bus.PCSrcE | bus.PCSrcM;
  assign w_flush_d    = w_pc_pending | bus.PCSrcW | bus.BranchTakenD;

  // A held multiply freezes F/D/E and feeds bubbles into Memory; otherwise normal hazards apply.
  always_comb begin
    bus.StallF = w_ldr_stall | w_pc_pending;
    bus.StallD = w_ldr_stall & ~w_flush_d;
    bus.StallE = 1'b0;
    bus.FlushD = w_flush_d;
    bus.FlushE = w_ldr_stall | bus.BranchTakenD;
    bus.FlushM = 1'b0;
    if (w_busy) begin
      bus.StallF = 1'b1;
      bus.StallD = 1'b1;
      bus.StallE = 1'b1;
      bus.FlushD = 1'b0;
      bus.FlushE = 1'b0;
      bus.FlushM = 1'b1;
    end
  end

  assign bus.MulBusyE = w_busy;
  assign bus.MulDoneE = w_done;

endmodule

// File: tb/tb_hazard_mul_ctrl.sv
// Scoreboard bench for hazard_mul_ctrl: two instances (MUL_CYCLES=3 and 4) share clk/reset.
module tb_hazard_mul_ctrl;

  typedef struct packed {
    logic [1:0] fa, fb, fc, ia, ib, ic;
    logic sf, sd, se, fd, fe, fm, busy, done;
  } out_t;

  localparam logic [7:0] S_BUSY = 8'b1110_0110;
  localparam logic [7:0] S_DONE = 8'b0000_0001;
  localparam logic [7:0] S_ZERO = 8'b0000_0000;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  out_t q[$];
  out_t act, exp_v;

  hazard_mul_ctrl_if if3 ();
  hazard_mul_ctrl_if if4 ();

  hazard_mul_ctrl #(.MUL_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));
  hazard_mul_ctrl #(.MUL_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [11:0] f, input logic [7:0] s);
    return {f, s};
  endfunction

  function automatic out_t get3();
    return {if3.ForwardAE, if3.ForwardBE, if3.ForwardCE, if3.ForwardAEIndex, if3.ForwardBEIndex,
            if3.ForwardCEIndex, if3.StallF, if3.StallD, if3.StallE, if3.FlushD, if3.FlushE,
            if3.FlushM, if3.MulBusyE, if3.MulDoneE};
  endfunction

  function automatic out_t get4();
    return {if4.ForwardAE, if4.ForwardBE, if4.ForwardCE, if4.ForwardAEIndex, if4.ForwardBEIndex,
            if4.ForwardCEIndex, if4.StallF, if4.StallD, if4.StallE, if4.FlushD, if4.FlushE,
            if4.FlushM, if4.MulBusyE, if4.MulDoneE};
  endfunction

  task automatic clear_inputs();
    {if3.Match_1E_M, if3.Match_1E_W, if3.Match_2E_M, if3.Match_2E_W, if3.Match_3E_M,
     if3.Match_3E_W, if3.Match_1E_M_Index, if3.Match_1E_W_Index, if3.Match_2E_M_Index,
     if3.Match_2E_W_Index, if3.Match_3E_M_Index, if3.Match_3E_W_Index, if3.Match_12D_E,
     if3.RegWriteM, if3.RegWriteW, if3.WriteBackM, if3.WriteBackW, if3.MemtoRegE,
     if3.PCSrcD, if3.PCSrcE, if3.PCSrcM, if3.PCSrcW, if3.BranchTakenD, if3.MulStartE} = '0;
    {if4.Match_1E_M, if4.Match_1E_W, if4.Match_2E_M, if4.Match_2E_W, if4.Match_3E_M,
     if4.Match_3E_W, if4.Match_1E_M_Index, if4.Match_1E_W_Index, if4.Match_2E_M_Index,
     if4.Match_2E_W_Index, if4.Match_3E_M_Index, if4.Match_3E_W_Index, if4.Match_12D_E,
     if4.RegWriteM, if4.RegWriteW, if4.WriteBackM, if4.WriteBackW, if4.MemtoRegE,
     if4.PCSrcD, if4.PCSrcE, if4.PCSrcM, if4.PCSrcW, if4.BranchTakenD, if4.MulStartE} = '0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    clear_inputs();
    q.push_back(mk(12'h000, S_ZERO));
    q.push_back(mk(12'h000, S_ZERO));
    @(negedge clk);
    act = get3(); exp_v = q.pop_front(); total++;
    if (act !== exp_v) begin bad++; $display("FAIL reset_dut3 act=%h req=%h", act, exp_v); end
    act = get4(); exp_v = q.pop_front(); total++;
    if (act !== exp_v) begin bad++; $display("FAIL reset_dut4 act=%h req=%h", act, exp_v); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_forward();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      case (i)
        0: begin
          {if3.Match_1E_M, if3.RegWriteM, if3.Match_1E_W, if3.RegWriteW} = 4'b1111;
          q.push_back(mk(12'b10_00_00_00_00_00, S_ZERO));
        end
        1: begin
          {if3.Match_1E_M, if3.Match_1E_W, if3.RegWriteW} = 3'b111;
          q.push_back(mk(12'b01_00_00_00_00_00, S_ZERO));
        end
        2: begin
          {if3.Match_1E_M, if3.Match_1E_W, if3.RegWriteW, if3.Match_3E_W} = 4'b1111;
          q.push_back(mk(12'b01_00_01_00_00_00, S_ZERO));
        end
        default: begin
          {if3.Match_1E_M, if3.RegWriteM, if3.Match_2E_M, if3.Match_3E_W} = 4'b1111;
          q.push_back(mk(12'b10_10_00_00_00_00, S_ZERO));
        end
      endcase
      @(negedge clk);
      act = get3(); exp_v = q.pop_front(); total++;
      if (act !== exp_v) begin bad++; $display("FAIL fwd_step%0d act=%h req=%h", i, act, exp_v); end
    end
  endtask

  task automatic test_index();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      {if3.WriteBackW, if3.Match_2E_W_Index} = 2'b11;
      if (i >= 1) {if3.WriteBackM, if3.Match_2E_M_Index} = 2'b11;
      if (i == 2) {if3.Match_1E_M_Index, if3.Match_3E_W_Index} = 2'b11;
      case (i)
        0:       q.push_back(mk(12'b00_00_00_00_01_00, S_ZERO));
        1:       q.push_back(mk(12'b00_00_00_00_10_00, S_ZERO));
        default: q.push_back(mk(12'b00_00_00_10_10_01, S_ZERO));
      endcase
      @(negedge clk);
      act = get3(); exp_v = q.pop_front(); total++;
      if (act !== exp_v) begin bad++; $display("FAIL idx_step%0d act=%h req=%h", i, act, exp_v); end
    end
  endtask

  task automatic test_ldr_stall();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (i == 0) begin
        {if3.Match_12D_E, if3.MemtoRegE} = 2'b11;
        q.push_back(mk(12'h000, 8'b1100_1000));
      end else begin
        q.push_back(mk(12'h000, S_ZERO));
      end
      @(negedge clk);
      act = get3(); exp_v = q.pop_front(); total++;
      if (act !== exp_v) begin bad++; $display("FAIL ldr_step%0d act=%h req=%h", i, act, exp_v); end
    end
  endtask

  task automatic test_pc_branch();
    logic [3:0] pc_tab [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
    logic [7:0] s_tab  [6] = '{8'b1001_0000, 8'b1001_0000, 8'b1001_0000, 8'b0001_0000,
                               8'b0000_0000, 8'b0001_1000};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      {if3.PCSrcD, if3.PCSrcE, if3.PCSrcM, if3.PCSrcW} = pc_tab[i];
      if (i == 5) if3.BranchTakenD = 1'b1;
      q.push_back(mk(12'h000, s_tab[i]));
      @(negedge clk);
      act = get3(); exp_v = q.pop_front(); total++;
      if (act !== exp_v) begin bad++; $display("FAIL pc_step%0d act=%h req=%h", i, act, exp_v); end
    end
  endtask

  task automatic test_back_to_back();
    logic       st_tab [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] s_tab  [7] = '{S_BUSY, S_BUSY, S_DONE, S_BUSY, S_BUSY, S_DONE, S_ZERO};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      if3.MulStartE = st_tab[i];
      q.push_back(mk(12'h000, s_tab[i]));
      @(negedge clk);
      act = get3(); exp_v = q.pop_front(); total++;
      if (act !== exp_v) begin bad++; $display("FAIL mul3_cyc%0d act=%h req=%h", i + 1, act, exp_v); end
    end
  endtask

  task automatic test_mul4();
    logic       st_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] s_tab  [5] = '{S_BUSY, S_BUSY, S_BUSY, S_DONE, S_ZERO};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      if4.MulStartE = st_tab[i];
      q.push_back(mk(12'h000, s_tab[i]));
      @(negedge clk);
      act = get4(); exp_v = q.pop_front(); total++;
      if (act !== exp_v) begin bad++; $display("FAIL mul4_cyc%0d act=%h req=%h", i + 1, act, exp_v); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] s_tab [3] = '{S_BUSY, S_BUSY, S_ZERO};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (i < 2) if4.MulStartE = 1'b1;
      if (i == 1) if4.PCSrcW = 1'b1;
      q.push_back(mk(12'h000, s_tab[i]));
      @(negedge clk);
      act = get4(); exp_v = q.pop_front(); total++;
      if (act !== exp_v) begin bad++; $display("FAIL abort_cyc%0d act=%h req=%h", i + 1, act, exp_v); end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [7:0] s_tab [4] = '{S_BUSY, S_BUSY, S_ZERO, S_ZERO};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      if4.MulStartE = (i == 0);
      reset = (i == 1);
      q.push_back(mk(12'h000, s_tab[i]));
      @(negedge clk);
      act = get4(); exp_v = q.pop_front(); total++;
      if (act !== exp_v) begin bad++; $display("FAIL rstmid_cyc%0d act=%h req=%h", i + 1, act, exp_v); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_forward();
    test_index();
    test_ldr_stall();
    test_pc_branch();
    test_back_to_back();
    test_mul4();
    test_abort();
    test_reset_mid_mul();
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover act=%0d req=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

endmodule

// File: doc/hazard_mul_ctrl.md
# hazard_mul_ctrl

Pipeline hazard and sequencing controller for the five-stage ARM datapath. It generates the forwarding selects for the three execute-stage operand bypass paths and the three index-writeback bypass paths. It also produces stall/flush strobes for load-use, PC-write and decode-branch hazards. It owns a small FSM that holds a multiply in Execute for a configurable number of cycles. It sits beside the controller, consumes the datapath's `Match_*` comparator outputs plus stage control bits, and drives the datapath's `Forward*`, `Stall*` and `Flush*` inputs.

## Interface
- `MUL_CYCLES`, 3, cycles a multiply occupies Execute; legal range 2..16
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high
- `Match_1E_M`, `Match_1E_W`, `Match_2E_M`, `Match_2E_W`, `Match_3E_M`, `Match_3E_W`  in  1 each  WA3 vs RA1E/RA2E/RA3E compares
- `Match_1E_M_Index` .. `Match_3E_W_Index`  in  1 each (6)  RA1M/RA1W vs RAxE compares
- `Match_12D_E`  in  1  Decode source matches Execute destination
- `RegWriteM`, `RegWriteW`, `WriteBackM`, `WriteBackW`  in  1 each  result-port and index-port write enables
- `MemtoRegE`  in  1  load in Execute
- `PCSrcD`, `PCSrcE`, `PCSrcM`, `PCSrcW`  in  1 each  instruction writes PC
- `BranchTakenD`  in  1  branch redirected in Decode
- `MulStartE`  in  1  multiply-class instruction in Execute
- `ForwardAE`, `ForwardBE`, `ForwardCE`  out  2 each  00 register file, 01 `ResultW`, 10 `ALUOutM`
- `ForwardAEIndex`, `ForwardBEIndex`, `ForwardCEIndex`  out  2 each  00 pass, 01 `ALUResultW`, 10 `ALUResultM`
- `StallF`, `StallD`, `StallE`  out  1 each  hold pipeline register
- `FlushD`, `FlushE`, `FlushM`  out  1 each  clear pipeline register (bubble)
- `MulBusyE`  out  1  multiply holding Execute
- `MulDoneE`  out  1  one-cycle pulse in the multiply's release cycle

## Operation
- Forwarding (combinational, per operand x ∈ {1,2,3}):
  - `ForwardxE` = 10 if `Match_xE_M & RegWriteM`.
  - Else 01 if `Match_xE_W & RegWriteW`.
  - Else 00.
  - Index selects use the same M-over-W priority with `Match_xE_M_Index & WriteBackM` and `Match_xE_W_Index & WriteBackW`.
- `LDRstall` = `Match_12D_E & MemtoRegE`.
- `PCWrPending` = `PCSrcD | PCSrcE | PCSrcM`.
- Multiply FSM, states IDLE and RUN, 4-bit down-counter `cnt`:
  - IDLE & `MulStartE`: `MulBusyE`=1; next state RUN, `cnt` ← `MUL_CYCLES`-2.
  - RUN & `cnt`≠0: `MulBusyE`=1; `cnt` ← `cnt`-1.
  - RUN & `cnt`=0: release cycle. `MulBusyE`=0, `MulDoneE`=1; next state IDLE. `MulStartE` is ignored in this cycle because it is still the same instruction.
  - A back-to-back multiply restarts from IDLE on the next cycle.
  - `PCSrcW` while in RUN: abort to IDLE, `cnt` ← 0. This is unreachable in legal flow but is defined.
- Strobes:
  - When `MulBusyE`=1: `StallF`=`StallD`=`StallE`=1, `FlushM`=1, `FlushD`=`FlushE`=0.
  - Otherwise: `StallF` = `LDRstall | PCWrPending`, `StallD` = `LDRstall`, `StallE`=0, `FlushD` = `PCWrPending | PCSrcW | BranchTakenD`, `FlushE` = `LDRstall | BranchTakenD`, `FlushM`=0.
  - When `StallD` and `FlushD` are both asserted, `FlushD` wins.

## Timing
- All outputs are combinational from inputs and FSM state; there is no added latency.
- Only the FSM state and `cnt` are registered; they update on the rising `clk`.
- Reset: state IDLE, `cnt`=0. With all inputs low, every output is 0.
- Reset asserted mid-multiply: the FSM returns to IDLE on that edge, and `MulBusyE`/`MulDoneE` go low the next cycle.
- A multiply occupies Execute for exactly `MUL_CYCLES` cycles with `MUL_CYCLES`-1 stall cycles. `MulDoneE` fires in cycle `MUL_CYCLES`, counting the entry cycle as 1.

## Structure
- Shared package `hazard_pkg` holds:
  - Forward encodings `FWD_RF`=2'b00, `FWD_W`=2'b01, `FWD_M`=2'b10.
  - FSM state enum `mul_state_t` {IDLE, RUN}.
- One sub-module, `fwd_sel`, instantiated six times: inputs matchM, matchW, weM, weW; output 2-bit select.
- The FSM and strobe logic live in the top module.

## Test plan
- `Match_1E_M`=1, `RegWriteM`=1, `Match_1E_W`=1, `RegWriteW`=1 -> `ForwardAE`=10. Drop `RegWriteM` -> 01.
- `Match_12D_E`=1, `MemtoRegE`=1 -> `StallF`=`StallD`=`FlushE`=1, `FlushD`=0, for exactly one cycle.
- `MUL_CYCLES`=3, `MulStartE` high 3 cycles:
  - `MulBusyE`/`StallE`/`FlushM` high in cycles 1–2.
  - `MulDoneE` high in cycle 3 only.
  - Second consecutive multiply restarts in cycle 4.
- `PCSrcD` pulse propagating D→E→M→W -> `StallF`=1 for 3 cycles, then `FlushD`=1 for 4 cycles. `BranchTakenD` alone -> `FlushD`=`FlushE`=1 that cycle.
- Reset asserted in the second busy cycle of a `MUL_CYCLES`=4 multiply -> all outputs 0 next cycle with `MulStartE` low; FSM in IDLE.
- `WriteBackW`=1, `Match_2E_W_Index`=1, `WriteBackM`=0 -> `ForwardBEIndex`=01. Add `WriteBackM`=1, `Match_2E_M_Index`=1 -> 10.
